// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the shared-memory / shared-ALU datapath.
// Moore outputs from state and latched opcode; pc_en also looks at zero and mem_ready.
module multicycle_control #(
  parameter int OP_W     = 6,
  parameter int DEC_BITS = 4,
  parameter int MEM_TO   = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] OPcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            Reg_Dst,
  output logic            Reg_w,
  output logic [1:0]      ALU_OP,
  output logic            ALU_src_a,
  output logic [1:0]      ALU_src_b,
  output logic            Mem_r,
  output logic            Mem_w,
  output logic            Mem_to_reg,
  output logic            IorD,
  output logic            ir_w,
  output logic            pc_en,
  output logic [1:0]      pc_src,
  output logic            trap,
  output logic [3:0]      state
);

  localparam int CNT_W = (MEM_TO < 1) ? 1 : $clog2(MEM_TO + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TO);

  localparam logic [DEC_BITS-1:0] OP_RTYPE = DEC_BITS'(4'h0);
  localparam logic [DEC_BITS-1:0] OP_ADDI  = DEC_BITS'(4'h9);
  localparam logic [DEC_BITS-1:0] OP_ORI   = DEC_BITS'(4'hD);
  localparam logic [DEC_BITS-1:0] OP_LW    = DEC_BITS'(4'h3);
  localparam logic [DEC_BITS-1:0] OP_SW    = DEC_BITS'(4'hB);
  localparam logic [DEC_BITS-1:0] OP_BEQ   = DEC_BITS'(4'h4);
  localparam logic [DEC_BITS-1:0] OP_J     = DEC_BITS'(4'h2);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_BRANCH = 4'd4,
    S_JUMP   = 4'd5,
    S_MEM    = 4'd6,
    S_WB     = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  generate
    if (DEC_BITS > OP_W || DEC_BITS < 4) begin : g_bad_dec_bits
      $error("multicycle_control: DEC_BITS must be within [4, OP_W]");
    end
    if (MEM_TO < 1) begin : g_bad_mem_to
      $error("multicycle_control: MEM_TO must be at least 1");
    end
    // Upper opcode bits are deliberately ignored by the decoder.
    if (OP_W > DEC_BITS) begin : g_unused_hi
      logic unused_op_hi;
      assign unused_op_hi = ^OPcode[OP_W-1:DEC_BITS];
    end
  endgenerate

  state_t              state_reg;
  state_t              state_next;
  logic [DEC_BITS-1:0] op_q;
  logic [DEC_BITS-1:0] dec_op;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [CNT_W-1:0]    wait_cnt_next;
  logic                timeout;
  logic                op_is_lw;
  logic                op_is_sw;

  assign dec_op   = OPcode[DEC_BITS-1:0];
  assign op_is_lw = (op_q == OP_LW);
  assign op_is_sw = (op_q == OP_SW);
  assign timeout  = (wait_cnt_reg == WAIT_LIMIT) && !mem_ready;
  assign state    = state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      op_q         <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_DECODE) begin
        op_q <= dec_op;
      end
    end
  end

  // Counter only runs while parked in a memory-wait state; leaving the state restarts it.
  always_comb begin
    wait_cnt_next = '0;
    if (state_next == state_reg && !mem_ready &&
        (state_reg == S_FETCH || state_reg == S_MEM)) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    Reg_Dst    = 1'b0;
    Reg_w      = 1'b0;
    ALU_OP     = 2'b00;
    ALU_src_a  = 1'b0;
    ALU_src_b  = 2'b00;
    Mem_r      = 1'b0;
    Mem_w      = 1'b0;
    Mem_to_reg = 1'b0;
    IorD       = 1'b0;
    ir_w       = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    trap       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        Mem_r     = 1'b1;
        ALU_src_b = 2'b01;
        if (mem_ready) begin
          // Loads are held off while reset is asserted so nothing is captured.
          ir_w       = !rst;
          pc_en      = !rst;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        ALU_src_b = 2'b11;
        case (dec_op)
          OP_RTYPE:                      state_next = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LW, OP_SW: state_next = S_EXEC_I;
          OP_BEQ:                        state_next = S_BRANCH;
          OP_J:                          state_next = S_JUMP;
          default:                       state_next = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        ALU_src_a  = 1'b1;
        ALU_OP     = 2'b11;
        state_next = S_WB;
      end

      S_EXEC_I: begin
        ALU_src_a  = 1'b1;
        ALU_src_b  = 2'b10;
        ALU_OP     = (op_q == OP_ORI) ? 2'b10 : 2'b00;
        state_next = (op_is_lw || op_is_sw) ? S_MEM : S_WB;
      end

      S_BRANCH: begin
        ALU_src_a  = 1'b1;
        ALU_OP     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = zero;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM: begin
        IorD  = 1'b1;
        Mem_r = op_is_lw;
        Mem_w = op_is_sw;
        if (mem_ready) begin
          state_next = op_is_lw ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_next = S_TRAP;
        end
      end

      S_WB: begin
        Reg_w      = 1'b1;
        Reg_Dst    = (op_q == OP_RTYPE);
        Mem_to_reg = op_is_lw;
        state_next = S_FETCH;
      end

      S_TRAP: begin
        trap       = 1'b1;
        state_next = S_TRAP;
      end

      default: begin
        state_next = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs are queued
// as stimulus is applied and compared against the DUT mid-cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] OPcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       Reg_Dst, Reg_w, ALU_src_a, Mem_r, Mem_w, Mem_to_reg, IorD, ir_w, pc_en, trap;
  logic [1:0] ALU_OP, ALU_src_b, pc_src;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control #(.OP_W(6), .DEC_BITS(4), .MEM_TO(15)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .zero(zero), .mem_ready(mem_ready),
    .Reg_Dst(Reg_Dst), .Reg_w(Reg_w), .ALU_OP(ALU_OP), .ALU_src_a(ALU_src_a),
    .ALU_src_b(ALU_src_b), .Mem_r(Mem_r), .Mem_w(Mem_w), .Mem_to_reg(Mem_to_reg),
    .IorD(IorD), .ir_w(ir_w), .pc_en(pc_en), .pc_src(pc_src), .trap(trap), .state(state)
  );

  wire [19:0] out_vec = {Reg_Dst, Reg_w, ALU_OP, ALU_src_a, ALU_src_b, Mem_r, Mem_w,
                         Mem_to_reg, IorD, ir_w, pc_en, pc_src, trap, state};

  typedef struct {
    logic [3:0] st;
    logic [5:0] op;
    logic       rdy;
    logic       zr;
  } step_t;

  step_t       steps[$];
  logic [19:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference output table for one cycle, in out_vec order.
  function automatic logic [19:0] exp_out(input logic [3:0] st, input logic [3:0] op,
                                          input logic zr, input logic rdy, input logic rs);
    logic rd, rw, sa, mr, mw, m2r, iord, irw, pce, tr;
    logic [1:0] aop, sb, ps;
    {rd, rw, sa, mr, mw, m2r, iord, irw, pce, tr} = '0;
    aop = 2'b00; sb = 2'b00; ps = 2'b00;
    case (st)
      4'd0: begin mr = 1'b1; sb = 2'b01; irw = rdy && !rs; pce = rdy && !rs; end
      4'd1: sb = 2'b11;
      4'd2: begin sa = 1'b1; aop = 2'b11; end
      4'd3: begin sa = 1'b1; sb = 2'b10; aop = (op == 4'hD) ? 2'b10 : 2'b00; end
      4'd4: begin sa = 1'b1; aop = 2'b01; ps = 2'b01; pce = zr; end
      4'd5: begin ps = 2'b10; pce = 1'b1; end
      4'd6: begin iord = 1'b1; mr = (op == 4'h3); mw = (op == 4'hB); end
      4'd7: begin rw = 1'b1; rd = (op == 4'h0); m2r = (op == 4'h3); end
      4'd8: tr = 1'b1;
      default: ;
    endcase
    return {rd, rw, aop, sa, sb, mr, mw, m2r, iord, irw, pce, ps, tr, st};
  endfunction

  task automatic add_steps(input logic [3:0] st, input logic [5:0] op,
                           input logic rdy, input logic zr, input int n);
    for (int k = 0; k < n; k++) steps.push_back('{st: st, op: op, rdy: rdy, zr: zr});
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    OPcode    = 6'h00;
    @(posedge clk); #1;
    checks++;
    if (out_vec !== exp_out(4'd0, 4'h0, 1'b0, 1'b1, 1'b1)) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", out_vec, exp_out(4'd0, 4'h0, 1'b0, 1'b1, 1'b1));
    end
    rst = 1'b0;
    $display("tx reset: outputs held at FETCH values");
  endtask

  task automatic test_r_type();
    step_t s; logic [19:0] e; int cyc = 0;
    add_steps(4'd0, 6'h00, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h00, 1'b1, 1'b0, 1);
    add_steps(4'd2, 6'h00, 1'b1, 1'b0, 1);
    add_steps(4'd7, 6'h00, 1'b1, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL r_type cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("tx r_type: %0d cycles", cyc);
  endtask

  task automatic test_lw_wait();
    step_t s; logic [19:0] e; int cyc = 0;
    add_steps(4'd0, 6'h03, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h03, 1'b0, 1'b0, 1);
    add_steps(4'd3, 6'h03, 1'b0, 1'b0, 1);
    add_steps(4'd6, 6'h03, 1'b0, 1'b0, 3);
    add_steps(4'd6, 6'h03, 1'b1, 1'b0, 1);
    add_steps(4'd7, 6'h03, 1'b0, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL lw_wait cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("tx lw_wait: %0d cycles", cyc);
  endtask

  task automatic test_branch_jump();
    step_t s; logic [19:0] e; int cyc = 0;
    add_steps(4'd0, 6'h04, 1'b1, 1'b1, 1);
    add_steps(4'd1, 6'h04, 1'b0, 1'b1, 1);
    add_steps(4'd4, 6'h04, 1'b0, 1'b1, 1);
    add_steps(4'd0, 6'h04, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h04, 1'b0, 1'b0, 1);
    add_steps(4'd4, 6'h04, 1'b0, 1'b0, 1);
    add_steps(4'd0, 6'h02, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h02, 1'b0, 1'b0, 1);
    add_steps(4'd5, 6'h02, 1'b0, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL branch_jump cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("tx branch_jump: %0d cycles", cyc);
  endtask

  task automatic test_ori_sw();
    step_t s; logic [19:0] e; int cyc = 0;
    // ori carries junk in the ignored upper opcode bits.
    add_steps(4'd0, 6'h3D, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h3D, 1'b0, 1'b0, 1);
    add_steps(4'd3, 6'h3D, 1'b0, 1'b0, 1);
    add_steps(4'd7, 6'h3D, 1'b0, 1'b0, 1);
    add_steps(4'd0, 6'h0B, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h0B, 1'b0, 1'b0, 1);
    add_steps(4'd3, 6'h0B, 1'b0, 1'b0, 1);
    add_steps(4'd6, 6'h0B, 1'b1, 1'b0, 1);
    add_steps(4'd0, 6'h0B, 1'b0, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL ori_sw cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      checks++;
      if ((Mem_r && Mem_w) || (Reg_w && Mem_w)) begin
        errors++;
        $display("FAIL ori_sw_exclusive cyc %0d: got Mem_r=%b Mem_w=%b Reg_w=%b expected no overlap",
                 cyc, Mem_r, Mem_w, Reg_w);
      end
      cyc++;
      @(posedge clk); #1;
    end
    $display("tx ori_sw: %0d cycles", cyc);
  endtask

  task automatic test_illegal();
    step_t s; logic [19:0] e; int cyc = 0;
    add_steps(4'd0, 6'h07, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h07, 1'b0, 1'b0, 1);
    for (int k = 0; k < 21; k++)
      add_steps(4'd8, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL illegal cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    rst = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if (out_vec !== exp_out(4'd0, OPcode[3:0], zero, 1'b1, 1'b1)) begin
      errors++;
      $display("FAIL illegal_rst_clear: got %h expected %h", out_vec, exp_out(4'd0, OPcode[3:0], zero, 1'b1, 1'b1));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("tx illegal: %0d cycles then reset", cyc);
  endtask

  task automatic test_timeout();
    step_t s; logic [19:0] e; int cyc = 0;
    add_steps(4'd0, 6'h00, 1'b0, 1'b0, 16);
    add_steps(4'd8, 6'h00, 1'b0, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL fetch_timeout cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;
    // Ready on the last allowed FETCH cycle wins; then lw times out in MEM.
    add_steps(4'd0, 6'h00, 1'b0, 1'b0, 15);
    add_steps(4'd0, 6'h00, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h00, 1'b0, 1'b0, 1);
    add_steps(4'd2, 6'h00, 1'b0, 1'b0, 1);
    add_steps(4'd7, 6'h00, 1'b0, 1'b0, 1);
    add_steps(4'd0, 6'h03, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h03, 1'b0, 1'b0, 1);
    add_steps(4'd3, 6'h03, 1'b0, 1'b0, 1);
    add_steps(4'd6, 6'h03, 1'b0, 1'b0, 16);
    add_steps(4'd8, 6'h03, 1'b0, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL ready_wins_mem_timeout cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("tx timeout: %0d cycles", cyc);
  endtask

  task automatic test_reset_mid_write();
    step_t s; logic [19:0] e; int cyc = 0;
    add_steps(4'd0, 6'h0B, 1'b1, 1'b0, 1);
    add_steps(4'd1, 6'h0B, 1'b0, 1'b0, 1);
    add_steps(4'd3, 6'h0B, 1'b0, 1'b0, 1);
    while (steps.size() > 0) begin
      s = steps.pop_front();
      OPcode = s.op; mem_ready = s.rdy; zero = s.zr;
      exp_q.push_back(exp_out(s.st, s.op[3:0], s.zr, s.rdy, 1'b0));
      #2;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        errors++;
        $display("FAIL sw_to_mem cyc %0d: got %h expected %h", cyc, out_vec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (Mem_w !== 1'b1 || state !== 4'd6) begin
      errors++;
      $display("FAIL sw_mem_write: got state %0d Mem_w %b expected state 6 Mem_w 1", state, Mem_w);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_vec !== exp_out(4'd0, 4'hB, zero, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL async_reset_abort: got %h expected %h", out_vec, exp_out(4'd0, 4'hB, zero, 1'b0, 1'b1));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("tx reset_mid_write: %0d cycles then async reset", cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch_jump();
    test_ori_sw();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    test_r_type();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
